// File: rtl/mem_stream_reader.sv
// Read-side DMA stage: fetches a contiguous run of RAM words and streams them out
// over valid/ready, absorbing the RAM's registered read latency in a 4-entry FIFO.
module mem_stream_reader #(
  parameter int unsigned MEMORY_BUS_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH       = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_in,
  input  logic [ADDR_WIDTH-1:0]       base_addr_in,
  input  logic [ADDR_WIDTH:0]         length_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        mem_enable_out,
  output logic                        mem_wb_out,
  output logic [ADDR_WIDTH-1:0]       mem_addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
  output logic                        stream_valid_out,
  input  logic                        stream_ready_in,
  output logic [MEMORY_BUS_WIDTH-1:0] stream_data_out,
  output logic                        stream_last_out
);

  localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       base_q, addr_q;
  logic [ADDR_WIDTH:0]         len_q, issue_cnt_q, beat_cnt_q;
  logic                        pending_q;
  logic [MEMORY_BUS_WIDTH-1:0] fifo_q [4];
  logic [1:0]                  wr_ptr_q, rd_ptr_q;
  logic [2:0]                  fifo_cnt_q;

  logic                        start_ok, issue, issue_last, push, pop, last_beat, fifo_valid;
  logic [ADDR_WIDTH-1:0]       issue_addr;

  // Credit rule: FIFO slots plus the read still in flight may never exceed the depth.
  assign start_ok   = (state_q == StIdle) && start_in;
  assign issue      = (state_q == StRead) && ((fifo_cnt_q + {2'b00, pending_q}) < 3'd4);
  assign issue_last = (issue_cnt_q == (len_q - CntOne));
  assign issue_addr = base_q + issue_cnt_q[ADDR_WIDTH-1:0];
  assign push       = pending_q;
  assign fifo_valid = (fifo_cnt_q != 3'd0);
  assign pop        = fifo_valid && stream_ready_in;
  assign last_beat  = (beat_cnt_q == (len_q - CntOne));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = (length_in == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (issue && issue_last) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (pop && last_beat) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_out         = (state_q == StRead) || (state_q == StFlush);
    done_out         = (state_q == StDone);
    mem_enable_out   = issue;
    mem_wb_out       = 1'b0;
    mem_addr_out     = issue ? issue_addr : addr_q;
    mem_data_out     = '0;
    stream_valid_out = fifo_valid;
    // Stale FIFO contents stay hidden so the data output reads zero when idle.
    stream_data_out  = fifo_valid ? fifo_q[rd_ptr_q] : '0;
    stream_last_out  = fifo_valid && last_beat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      pending_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      pending_q <= issue;
      if (start_ok) begin
        base_q      <= base_addr_in;
        len_q       <= length_in;
        issue_cnt_q <= '0;
        beat_cnt_q  <= '0;
      end
      if (issue) begin
        issue_cnt_q <= issue_cnt_q + CntOne;
        addr_q      <= issue_addr;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 2'd1;
        beat_cnt_q <= beat_cnt_q + CntOne;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: RAM model with registered reads, directed scenarios
// and randomized transfers checked against a queue of expected words.
module tb_mem_stream_reader;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_in = 1'b0;
  logic [AW-1:0] base_addr_in = '0;
  logic [AW:0]   length_in = '0;
  logic          busy_out, done_out, mem_enable_out, mem_wb_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in = '0;
  logic          stream_valid_out;
  logic          stream_ready_in = 1'b0;
  logic [DW-1:0] stream_data_out;
  logic          stream_last_out;

  logic [DW-1:0] ram [1024];

  int passed = 0;
  int total  = 0;
  int issued, beats, first_beat_c, last_beat_c, done_c, issued_at_hold, last_count;
  int got[$];

  mem_stream_reader #(.MEMORY_BUS_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .start_in         (start_in),
    .base_addr_in     (base_addr_in),
    .length_in        (length_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .mem_enable_out   (mem_enable_out),
    .mem_wb_out       (mem_wb_out),
    .mem_addr_out     (mem_addr_out),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .stream_valid_out (stream_valid_out),
    .stream_ready_in  (stream_ready_in),
    .stream_data_out  (stream_data_out),
    .stream_last_out  (stream_last_out)
  );

  always #5 clock = ~clock;

  // RAM port: read data registered, available the cycle after the address.
  always @(posedge clock) begin
    if (mem_enable_out) mem_data_in <= ram[mem_addr_out];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, busy_out, 0);
    chk({pfx, "_done"}, done_out, 0);
    chk({pfx, "_enable"}, mem_enable_out, 0);
    chk({pfx, "_wb"}, mem_wb_out, 0);
    chk({pfx, "_addr"}, mem_addr_out, 0);
    chk({pfx, "_mem_data"}, mem_data_out, 0);
    chk({pfx, "_valid"}, stream_valid_out, 0);
    chk({pfx, "_last"}, stream_last_out, 0);
    chk({pfx, "_sdata"}, stream_data_out, 0);
  endtask

  // mode 0: ready high; 1: pattern 1,0,0 from cycle 0; 2: random; 3: low through cycle hold
  function automatic logic ready_for(input int mode, input int c, input int hold);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      3:       return c > hold;
      default: return 1'b1;
    endcase
  endfunction

  // Runs one transfer from start (cycle 0) to the cycle after done_out.
  task automatic xfer(input int base, input int len, input int mode, input int hold);
    int            exp_q[$];
    logic          rdy, pv, pr, pl;
    logic [DW-1:0] pd;
    bit            finished;
    for (int i = 0; i < len; i++) exp_q.push_back(int'(ram[(base + i) % 1024]));
    issued = 0; beats = 0; first_beat_c = -1; last_beat_c = -1; done_c = -1;
    issued_at_hold = -1; last_count = 0; got.delete();
    pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0; finished = 1'b0;
    start_in        = 1'b1;
    base_addr_in    = AW'(base);
    length_in       = (AW + 1)'(len);
    stream_ready_in = ready_for(mode, 0, hold);
    tick();
    start_in = 1'b0;
    for (int c = 1; c < 4000 && !finished; c++) begin
      if (mem_enable_out) begin
        chk("issue_addr", mem_addr_out, (base + issued) % 1024);
        chk("issue_within_length", issued < len, 1);
        chk("issue_wb", mem_wb_out, 0);
        issued++;
      end
      chk("outstanding_le_4", (issued - beats) <= 4, 1);
      if (pv && !pr) begin
        chk("stall_valid", stream_valid_out, 1);
        chk("stall_data", stream_data_out, pd);
        chk("stall_last", stream_last_out, pl);
      end
      rdy = ready_for(mode, c, hold);
      stream_ready_in = rdy;
      if (c == hold) issued_at_hold = issued;
      if (stream_last_out) last_count++;
      if (stream_valid_out && rdy) begin
        chk("beat_within_length", beats < len, 1);
        if (beats < len) chk("beat_data", stream_data_out, exp_q[beats]);
        chk("beat_last", stream_last_out, beats == len - 1);
        got.push_back(int'(stream_data_out));
        if (first_beat_c < 0) first_beat_c = c;
        last_beat_c = c;
        beats++;
      end
      if (done_out) begin
        done_c = c;
        chk("done_busy", busy_out, 0);
        chk("done_beats", beats, len);
        chk("done_issued", issued, len);
        finished = 1'b1;
      end else begin
        chk("busy", busy_out, len != 0);
      end
      pv = stream_valid_out; pr = rdy; pd = stream_data_out; pl = stream_last_out;
      tick();
    end
    if (!finished) chk("xfer_timeout", 0, 1);
  endtask

  initial begin
    int n;
    for (int j = 0; j < 1024; j++) ram[j] = DW'(1024 - j);

    reset = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Base 5, length 4, ready high: words in cycles 3..6, done in 7.
    xfer(5, 4, 0, 0);
    chk("t1_first_beat_cycle", first_beat_c, 3);
    chk("t1_last_beat_cycle", last_beat_c, 6);
    chk("t1_done_cycle", done_c, 7);
    chk("t1_last_count", last_count, 1);
    chk("t1_w0", got[0], 1019);
    chk("t1_w1", got[1], 1018);
    chk("t1_w2", got[2], 1017);
    chk("t1_w3", got[3], 1016);

    // Same transfer with toggling ready.
    xfer(5, 4, 1, 0);
    chk("t2_beats", got.size(), 4);
    chk("t2_w0", got[0], 1019);
    chk("t2_w3", got[3], 1016);

    // Address wrap.
    xfer(1022, 4, 0, 0);
    chk("t3_w0", got[0], 2);
    chk("t3_w1", got[1], 1);
    chk("t3_w2", got[2], 1024);
    chk("t3_w3", got[3], 1023);

    // Zero length.
    xfer(7, 0, 0, 0);
    chk("t4_done_cycle", done_c, 1);
    chk("t4_issued", issued, 0);
    chk("t4_no_beats", first_beat_c, -1);

    // Ready low for 10 cycles, length 8.
    xfer(100, 8, 3, 10);
    chk("t5_issued_while_stalled", issued_at_hold, 4);
    chk("t5_beats", got.size(), 8);
    chk("t5_w7", got[7], 1024 - 107);

    // Reset in the cycle after the 2nd beat of a length-6 transfer.
    start_in = 1'b1; base_addr_in = 10'd20; length_in = 11'd6; stream_ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    n = 0;
    for (int c = 1; c < 50 && n < 2; c++) begin
      if (stream_valid_out) n++;
      tick();
    end
    chk("t6_two_beats_seen", n, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs("t6_after_reset");
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_no_done", done_out, 0);
      chk("t6_no_valid", stream_valid_out, 0);
      chk("t6_no_enable", mem_enable_out, 0);
    end
    xfer(0, 2, 0, 0);
    chk("t6_w0", got[0], 1024);
    chk("t6_w1", got[1], 1023);

    // Randomized transfers, including a full-memory run.
    for (int k = 0; k < 10; k++) begin
      int b, l;
      b = int'($urandom_range(0, 1023));
      l = (k == 0) ? 1024 : int'($urandom_range(0, 24));
      xfer(b, l, (k == 0) ? 0 : 2, 0);
      chk("rand_beats", got.size(), l);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
